axi_stream_rx_block: RTL and testbench

AXI4-Stream slave that accepts DATA_WIDTH-bit beats from the message source and packs them into BLOCK_BEATS-beat blocks for the SHA3 absorb stage. It sits between the streaming input, which is driven by the team's AXI-Stream transmitter, and the sponge core. It presents each completed block on a valid/ready side port together with a valid-byte count, an end-of-message flag and the sideband fields. TKEEP handling lets the core pad partial final blocks.

---
 rtl/axi_stream_rx_block_if.sv | 27 ++
 rtl/axi_stream_rx_block.sv | 160 ++++++++++++++++
 tb/tb_axi_stream_rx_block.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_rx_block_if.sv
// AXI4-Stream beat channel between the message source and the block packer.
// A beat transfers on a rising ACLK edge where TVALID && TREADY; the master holds its payload stable until then.
interface axi_stream_rx_block_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  TVALID;
    logic                  TREADY;
    logic [DATA_WIDTH-1:0] TDATA;
    logic [NB-1:0]         TKEEP;
    logic [NB-1:0]         TSTRB;
    logic                  TDEST;
    logic                  TLAST;
    logic [3:0]            TUSER;
    logic [1:0]            TID;

    modport master (
        output TVALID, TDATA, TKEEP, TSTRB, TDEST, TLAST, TUSER, TID,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TKEEP, TSTRB, TDEST, TLAST, TUSER, TID,
        output TREADY
    );
endinterface

// File: rtl/axi_stream_rx_block.sv
// Packs AXI4-Stream beats into BLOCK_BEATS-beat blocks for the SHA3 absorb stage,
// zeroing unkept bytes and flagging TKEEP/sideband protocol violations.
module axi_stream_rx_block #(
    parameter  int DATA_WIDTH  = 16,
    parameter  int BLOCK_BEATS = 8,
    localparam int NB          = DATA_WIDTH / 8,
    localparam int BW          = DATA_WIDTH * BLOCK_BEATS,
    localparam int CW          = $clog2(BLOCK_BEATS * NB + 1)
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    axi_stream_rx_block_if.slave         s_axis,
    output logic [BW-1:0]                blk_data,
    output logic [CW-1:0]                blk_bytes,
    output logic                         blk_last,
    output logic [3:0]                   blk_user,
    output logic [1:0]                   blk_id,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic                         protocol_err,
    output logic [1:0]                   dbg_state
);
    localparam int CNTW = $clog2(BLOCK_BEATS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              release_blk;
    logic              close_blk;

    logic [CNTW-1:0]   cnt_q;
    logic [BW-1:0]     data_q;
    logic [CW-1:0]     bytes_q;
    logic              last_q;
    logic [3:0]        user_q;
    logic [1:0]        id_q;
    logic              err_q;

    logic [DATA_WIDTH-1:0] beat_masked;
    logic [CW-1:0]         keep_cnt;
    logic [NB:0]           keep_ext;
    logic                  keep_gap;
    logic                  keep_short;
    logic                  side_change;
    logic                  beat_err;

    logic                  unused_sideband;
    assign unused_sideband = ^{s_axis.TSTRB, s_axis.TDEST};

    assign close_blk = (cnt_q == CNTW'(BLOCK_BEATS - 1)) || s_axis.TLAST;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        release_blk = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (s_axis.TVALID) begin
                    accept = 1'b1;
                    if (close_blk) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (blk_ready) begin
                    release_blk = 1'b1;
                    state_d     = S_COLLECT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Unkept bytes are forced to zero so the core can pad without masking.
    always_comb begin
        beat_masked = '0;
        keep_cnt    = '0;
        for (int i = 0; i < NB; i++) begin
            if (s_axis.TKEEP[i]) begin
                beat_masked[i*8 +: 8] = s_axis.TDATA[i*8 +: 8];
            end
            keep_cnt = keep_cnt + CW'(s_axis.TKEEP[i]);
        end
    end

    // A contiguous low-aligned mask plus one is a power of two, so it shares no set bit with the mask.
    assign keep_ext    = {1'b0, s_axis.TKEEP};
    assign keep_gap    = |(keep_ext & (keep_ext + (NB+1)'(1)));
    assign keep_short  = !(&s_axis.TKEEP) && !s_axis.TLAST;
    assign side_change = (cnt_q != '0) && ((s_axis.TID != id_q) || (s_axis.TUSER != user_q));
    assign beat_err    = keep_gap || keep_short || side_change;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cnt_q   <= '0;
            data_q  <= '0;
            bytes_q <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                for (int k = 0; k < BLOCK_BEATS; k++) begin
                    if (cnt_q == CNTW'(k)) begin
                        data_q[k*DATA_WIDTH +: DATA_WIDTH] <= beat_masked;
                    end
                end
                bytes_q <= bytes_q + keep_cnt;
                cnt_q   <= cnt_q + CNTW'(1);
                if (cnt_q == '0) begin
                    user_q <= s_axis.TUSER;
                    id_q   <= s_axis.TID;
                end
                if (close_blk) begin
                    last_q <= s_axis.TLAST;
                end
                err_q <= beat_err;
            end else if (release_blk) begin
                data_q  <= '0;
                bytes_q <= '0;
                cnt_q   <= '0;
                last_q  <= 1'b0;
            end
        end
    end

    // Ready and valid come straight from the state register, never from TVALID.
    assign s_axis.TREADY = (state_q == S_COLLECT);
    assign blk_valid     = (state_q == S_HOLD);
    assign blk_data      = data_q;
    assign blk_bytes     = bytes_q;
    assign blk_last      = last_q;
    assign blk_user      = user_q;
    assign blk_id        = id_q;
    assign protocol_err  = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axi_stream_rx_block.sv
// Directed and randomized checks of axi_stream_rx_block against a message-level block model.
module tb_axi_stream_rx_block;
    localparam int DW = 16;
    localparam int BB = 8;
    localparam int NB = DW / 8;
    localparam int BW = DW * BB;
    localparam int CW = $clog2(BB * NB + 1);
    localparam int EW = BW + CW + 7;

    // clock / reset
    logic ACLK    = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_stream_rx_block_if #(.DATA_WIDTH(DW)) s_if ();

    logic [BW-1:0] blk_data;
    logic [CW-1:0] blk_bytes;
    logic          blk_last;
    logic [3:0]    blk_user;
    logic [1:0]    blk_id;
    logic          blk_valid;
    logic          blk_ready;
    logic          protocol_err;
    logic [1:0]    dbg_state_unused;

    axi_stream_rx_block #(.DATA_WIDTH(DW), .BLOCK_BEATS(BB)) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .s_axis       (s_if),
        .blk_data     (blk_data),
        .blk_bytes    (blk_bytes),
        .blk_last     (blk_last),
        .blk_user     (blk_user),
        .blk_id       (blk_id),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .protocol_err (protocol_err),
        .dbg_state    (dbg_state_unused)
    );

    int checks   = 0;
    int errors   = 0;
    int err_seen = 0;
    logic [EW-1:0] exp_q[$];
    logic          err_q[$];
    logic          err_pend = 1'b0;
    logic          mon_en   = 1'b0;
    bit            rnd_rdy  = 1'b0;

    // current message under construction
    logic [DW-1:0] m_data[64];
    logic [NB-1:0] m_keep[64];
    logic [3:0]    m_user[64];
    logic [1:0]    m_id[64];
    int            m_len;

    task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: blocks at each handshake, protocol_err one cycle after each accept
    always @(negedge ACLK) begin
        if (mon_en) begin
            check("protocol_err", EW'(protocol_err), EW'(err_pend));
            if (protocol_err) err_seen++;
            if (ARESETn && blk_valid && blk_ready) begin
                check("block_expected", EW'(exp_q.size() != 0), EW'(1));
                if (exp_q.size() != 0)
                    check("block", {blk_data, blk_bytes, blk_last, blk_user, blk_id}, exp_q.pop_front());
            end
            err_pend = 1'b0;
            if (ARESETn && s_if.TVALID && s_if.TREADY) begin
                check("accept_expected", EW'(err_q.size() != 0), EW'(1));
                if (err_q.size() != 0) err_pend = err_q.pop_front();
            end
        end
    end

    function automatic logic beat_err(input int j);
        int lo = (j / BB) * BB;
        bit seen_zero = 1'b0;
        bit gap = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (!m_keep[j][b]) seen_zero = 1'b1;
            else if (seen_zero) gap = 1'b1;
        end
        return gap || (m_keep[j] != '1 && j != m_len - 1) ||
               (j != lo && (m_id[j] != m_id[lo] || m_user[j] != m_user[lo]));
    endfunction

    // driver tasks
    task automatic drive_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l,
                              input logic [3:0] u, input logic [1:0] i, input logic e);
        int n = 0;
        err_q.push_back(e);
        s_if.TVALID = 1'b1;
        s_if.TDATA  = d;
        s_if.TKEEP  = k;
        s_if.TSTRB  = NB'($urandom);
        s_if.TDEST  = 1'($urandom);
        s_if.TLAST  = l;
        s_if.TUSER  = u;
        s_if.TID    = i;
        @(negedge ACLK);
        while (!s_if.TREADY && n < 100) begin
            @(posedge ACLK); #1;
            if (rnd_rdy) blk_ready = ($urandom_range(0, 3) != 0);
            n++;
            @(negedge ACLK);
        end
        check("accept_timeout", EW'(s_if.TREADY), EW'(1));
        @(posedge ACLK); #1;
        s_if.TVALID = 1'b0;
        if (rnd_rdy) blk_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_msg();
        for (int lo = 0; lo < m_len; lo += BB) begin
            logic [BW-1:0] blk;
            int bytes;
            int hi;
            blk   = '0;
            bytes = 0;
            hi    = (lo + BB < m_len) ? lo + BB : m_len;
            for (int j = lo; j < hi; j++) begin
                for (int b = 0; b < NB; b++) begin
                    if (m_keep[j][b]) begin
                        blk[((j - lo) * NB + b) * 8 +: 8] = m_data[j][b*8 +: 8];
                        bytes++;
                    end
                end
            end
            exp_q.push_back({blk, CW'(bytes), hi == m_len, m_user[lo], m_id[lo]});
        end
        @(posedge ACLK); #1;
        for (int j = 0; j < m_len; j++)
            drive_beat(m_data[j], m_keep[j], j == m_len - 1, m_user[j], m_id[j], beat_err(j));
    endtask

    task automatic fill_msg(input int len, input logic [3:0] u, input logic [1:0] i);
        m_len = len;
        for (int j = 0; j < len; j++) begin
            m_data[j] = DW'($urandom);
            m_keep[j] = '1;
            m_user[j] = u;
            m_id[j]   = i;
        end
    endtask

    initial begin
        s_if.TVALID = 1'b0;
        s_if.TDATA  = '0;
        s_if.TKEEP  = '0;
        s_if.TSTRB  = '0;
        s_if.TDEST  = 1'b0;
        s_if.TLAST  = 1'b0;
        s_if.TUSER  = '0;
        s_if.TID    = '0;
        blk_ready   = 1'b0;

        // reset values
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        mon_en = 1'b1;
        check("rst_tready", EW'(s_if.TREADY), EW'(0));
        check("rst_outputs", {blk_data, blk_bytes, blk_last, blk_user, blk_id}, '0);
        check("rst_valid_err", EW'({blk_valid, protocol_err}), EW'(0));
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("idle_tready", EW'(s_if.TREADY), EW'(0));
        @(negedge ACLK);
        check("collect_tready", EW'(s_if.TREADY), EW'(1));

        // full block, no TLAST
        @(posedge ACLK); #1;
        blk_ready = 1'b1;
        fill_msg(BB, 4'h3, 2'd1);
        for (int j = 0; j < BB; j++) m_data[j] = DW'(j + 1);
        m_len = BB + 1;
        m_keep[BB] = '1;
        m_data[BB] = '0;
        m_user[BB] = 4'h3;
        m_id[BB]   = 2'd1;
        m_len = BB;
        for (int lo = 0; lo < 1; lo++) begin
            logic [BW-1:0] blk;
            blk = '0;
            for (int j = 0; j < BB; j++) blk[j*DW +: DW] = m_data[j];
            exp_q.push_back({blk, CW'(BB * NB), 1'b0, 4'h3, 2'd1});
        end
        @(posedge ACLK); #1;
        for (int j = 0; j < BB; j++)
            drive_beat(m_data[j], 2'b11, 1'b0, 4'h3, 2'd1, 1'b0);
        @(negedge ACLK);
        check("full_valid", EW'({blk_valid, s_if.TREADY}), EW'(2'b10));
        check("full_data", EW'(blk_data), EW'(128'h0008_0007_0006_0005_0004_0003_0002_0001));
        check("full_bytes_last", EW'({blk_bytes, blk_last}), EW'({5'd16, 1'b0}));
        @(negedge ACLK);
        check("full_valid_drop", EW'({blk_valid, s_if.TREADY}), EW'(2'b01));

        // partial last block
        fill_msg(3, 4'h5, 2'd2);
        m_data[0] = 16'hAABB;
        m_data[1] = 16'hCCDD;
        m_data[2] = 16'h11EE;
        m_keep[2] = 2'b01;
        send_msg();
        @(negedge ACLK);
        check("partial_data", EW'(blk_data), EW'(48'h00EE_CCDD_AABB));
        check("partial_bytes_last", EW'({blk_bytes, blk_last}), EW'({5'd5, 1'b1}));

        // empty message padding block
        fill_msg(1, 4'h9, 2'd3);
        m_keep[0] = 2'b00;
        send_msg();
        @(negedge ACLK);
        check("empty_block", EW'({blk_valid, blk_data, blk_bytes, blk_last}), EW'({1'b1, 128'h0, 5'd0, 1'b1}));

        // backpressure: closed block held while next beat waits
        @(posedge ACLK); #1;
        blk_ready = 1'b0;
        fill_msg(BB, 4'hA, 2'd0);
        send_msg();
        fill_msg(3, 4'h6, 2'd1);
        s_if.TVALID = 1'b1;
        s_if.TDATA  = m_data[0];
        s_if.TKEEP  = m_keep[0];
        s_if.TLAST  = 1'b0;
        s_if.TUSER  = m_user[0];
        s_if.TID    = m_id[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            check("bp_hold", EW'({blk_valid, s_if.TREADY}), EW'(2'b10));
            check("bp_stable", {blk_data, blk_bytes, blk_last, blk_user, blk_id}, exp_q[0]);
        end
        @(posedge ACLK); #1;
        blk_ready = 1'b1;
        send_msg();

        // protocol errors, one pulse each
        begin
            int base;
            base = err_seen;
            fill_msg(3, 4'h1, 2'd0);
            m_keep[1] = 2'b10;
            send_msg();
            fill_msg(3, 4'h2, 2'd0);
            m_keep[1] = 2'b01;
            send_msg();
            fill_msg(4, 4'h4, 2'd2);
            m_id[2] = 2'd3;
            send_msg();
            repeat (3) @(posedge ACLK);
            #1;
            check("err_pulses", EW'(err_seen - base), EW'(3));
        end

        // reset mid-block
        @(posedge ACLK); #1;
        for (int j = 0; j < 3; j++) drive_beat(DW'($urandom), 2'b11, 1'b0, 4'h7, 2'd1, 1'b0);
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("midrst_outputs", {blk_data, blk_bytes, blk_last, blk_user, blk_id}, '0);
        check("midrst_ready_valid", EW'({s_if.TREADY, blk_valid, protocol_err}), EW'(0));
        @(negedge ACLK);
        check("midrst_collect", EW'(s_if.TREADY), EW'(1));
        fill_msg(BB, 4'hB, 2'd2);
        send_msg();

        // randomized messages with random block backpressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 25; n++) begin
            fill_msg($urandom_range(1, 20), 4'($urandom), 2'($urandom));
            for (int j = 0; j < m_len; j++) begin
                if ($urandom_range(0, 7) == 0) m_keep[j] = NB'($urandom);
                if ($urandom_range(0, 9) == 0) m_id[j] = 2'($urandom);
                if ($urandom_range(0, 9) == 0) m_user[j] = 4'($urandom);
            end
            if ($urandom_range(0, 1) == 0) m_keep[m_len-1] = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b00;
            send_msg();
        end
        rnd_rdy = 1'b0;
        @(posedge ACLK); #1;
        blk_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge ACLK);
        #1;
        check("drain_blocks", EW'(exp_q.size()), EW'(0));
        check("drain_accepts", EW'(err_q.size()), EW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
